// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and memory bus signal bundle for load_store_unit
interface load_store_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_fault;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [NB-1:0]     bus_be;
  logic [XLEN-1:0]   bus_wdata;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_ack;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, bus_rdata, bus_ack,
    input  req_ready, resp_valid, resp_rdata, resp_fault, bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, bus_rdata, bus_ack,
    output req_ready, resp_valid, resp_rdata, resp_fault, bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - request/response memory sequencer with byte lanes, ack timeout and load extension
// Optional feature: LSU_MISALIGNED_SPLIT_EN splits word-crossing accesses into two bus phases.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave lsu
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam int SIW  = $clog2(2 * XLEN);
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam int WDW  = 2 * XLEN;
`else
  localparam int WDW  = XLEN;
`endif

  typedef enum logic [1:0] {IDLE, BUS1, BUS2, RESP} state_e;

  state_e            state_q;
  logic [CNTW-1:0]   wait_q;
  logic [OFFW-1:0]   off_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              we_q;
  logic [XLEN-1:0]   rdata_lo_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [NB-1:0]     bus_be_q;
  logic [XLEN-1:0]   bus_wdata_q;
  logic              resp_valid_q;
  logic [XLEN-1:0]   resp_rdata_q;
  logic              resp_fault_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic              split_q;
  logic [NB-1:0]     be_hi_q;
  logic [XLEN-1:0]   wdata_hi_q;
`endif

  logic [OFFW-1:0]   off_d;
  logic [3:0]        nbytes_d;
  logic [2*NB-1:0]   lane_d;
  logic [WDW-1:0]    wdata_d;
  logic              split_d;
  logic              fault_d;
  logic [2*XLEN-1:0] rd_sh;
  logic [XLEN-1:0]   keep;
  logic [SIW-1:0]    sidx;
  logic              sign_fill;
  logic [XLEN-1:0]   load_res;
  logic              timed_out;

  // Lane mask spans two words so the split case can read its second half directly.
  always_comb begin
    off_d    = lsu.req_addr[OFFW-1:0];
    nbytes_d = 4'(1) << lsu.req_size;
    lane_d   = (((2 * NB)'(1) << nbytes_d) - (2 * NB)'(1)) << off_d;
    wdata_d  = WDW'(lsu.req_wdata) << (8 * off_d);
    split_d  = |lane_d[2*NB-1:NB];
`ifdef LSU_MISALIGNED_SPLIT_EN
    fault_d  = (lsu.req_size == 2'd3) && (XLEN < 64);
`else
    fault_d  = ((lsu.req_size == 2'd3) && (XLEN < 64)) || split_d;
`endif
  end

  // Load path: {word2, word1} >> 8*off, keep n bytes, fill above with the sign if asked.
  always_comb begin
    if (state_q == BUS2) begin
      rd_sh = {lsu.bus_rdata, rdata_lo_q} >> (8 * off_q);
    end else begin
      rd_sh = {{XLEN{1'b0}}, lsu.bus_rdata} >> (8 * off_q);
    end
    keep      = (XLEN'(1) << (8 << size_q)) - XLEN'(1);
    sidx      = SIW'((8 << size_q) - 1);
    sign_fill = signed_q && rd_sh[sidx];
    load_res  = (rd_sh[XLEN-1:0] & keep) | (sign_fill ? ~keep : '0);
    timed_out = (wait_q == CNTW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      off_q        <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      we_q         <= 1'b0;
      rdata_lo_q   <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q      <= 1'b0;
      be_hi_q      <= '0;
      wdata_hi_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (lsu.req_valid) begin
            off_q    <= off_d;
            size_q   <= lsu.req_size;
            signed_q <= lsu.req_signed;
            we_q     <= lsu.req_we;
            wait_q   <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q    <= split_d;
            be_hi_q    <= lane_d[2*NB-1:NB];
            wdata_hi_q <= wdata_d[2*XLEN-1:XLEN];
`endif
            if (fault_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q     <= BUS1;
              bus_req_q   <= 1'b1;
              bus_we_q    <= lsu.req_we;
              bus_addr_q  <= {lsu.req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
              bus_be_q    <= lane_d[NB-1:0];
              bus_wdata_q <= wdata_d[XLEN-1:0];
            end
          end
        end
        BUS1, BUS2: begin
          if (lsu.bus_ack) begin
            rdata_lo_q <= lsu.bus_rdata;
            wait_q     <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (state_q == BUS1 && split_q) begin
              state_q     <= BUS2;
              bus_addr_q  <= bus_addr_q + ADDR_W'(NB);
              bus_be_q    <= be_hi_q;
              bus_wdata_q <= wdata_hi_q;
            end else
`endif
            begin
              state_q      <= RESP;
              bus_req_q    <= 1'b0;
              bus_we_q     <= 1'b0;
              bus_be_q     <= '0;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b0;
              resp_rdata_q <= we_q ? '0 : load_res;
            end
          end else if (timed_out) begin
            state_q      <= RESP;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_be_q     <= '0;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            wait_q <= wait_q + CNTW'(1);
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= '0;
        end
      endcase
    end
  end

  assign lsu.req_ready  = (state_q == IDLE);
  assign lsu.resp_valid = resp_valid_q;
  assign lsu.resp_rdata = resp_rdata_q;
  assign lsu.resp_fault = resp_fault_q;
  assign lsu.bus_req    = bus_req_q;
  assign lsu.bus_we     = bus_we_q;
  assign lsu.bus_addr   = bus_addr_q;
  assign lsu.bus_be     = bus_be_q;
  assign lsu.bus_wdata  = bus_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a wait-state bus responder
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.XLEN(32), .ADDR_W(32)) dut_if ();

  load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .lsu (dut_if.slave)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  resp_t       exp_q[$];
  bus_t        bus_q[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          wait_cfg = 0;
  int          waited   = 0;
  int          hi_cnt   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (dut_if.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 1, 0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", dut_if.resp_rdata, e.rdata);
        check("resp_fault", dut_if.resp_fault, e.fault);
        check("resp_latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  // Bus responder and phase checker; ack is driven wait_cfg cycles into each phase.
  always @(negedge clk) begin
    if (dut_if.bus_req === 1'b1) begin
      hi_cnt++;
      if (waited == 0) begin
        if (bus_q.size() == 0) begin
          check("unexpected_bus", 1, 0);
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          check("bus_we", dut_if.bus_we, b.we);
          check("bus_addr", dut_if.bus_addr, b.addr);
          check("bus_be", dut_if.bus_be, b.be);
          check("bus_wdata", dut_if.bus_wdata, b.wdata);
        end
      end
      if (waited >= wait_cfg) begin
        dut_if.bus_ack   = 1'b1;
        dut_if.bus_rdata = mem.exists(dut_if.bus_addr) ? mem[dut_if.bus_addr] : 32'h0;
        waited = 0;
      end else begin
        dut_if.bus_ack   = 1'b0;
        dut_if.bus_rdata = 32'h0;
        waited++;
      end
    end else begin
      dut_if.bus_ack   = 1'b0;
      dut_if.bus_rdata = 32'h0;
      waited = 0;
    end
  end

  task automatic expect_bus(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    bus_t b;
    b.we = we; b.addr = addr; b.be = be; b.wdata = wd;
    bus_q.push_back(b);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (dut_if.req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("req_ready_timeout", 0, 1);
  endtask

  task automatic send(input logic we, input logic [1:0] size, input logic sg,
                      input logic [31:0] addr, input logic [31:0] wd, input int w);
    wait_ready();
    wait_cfg = w;
    dut_if.req_we     = we;
    dut_if.req_size   = size;
    dut_if.req_signed = sg;
    dut_if.req_addr   = addr;
    dut_if.req_wdata  = wd;
    dut_if.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    dut_if.req_valid = 1'b0;
    dut_if.req_addr  = 32'hFFFF_FFFF;
    dut_if.req_wdata = 32'hA5A5_A5A5;
    dut_if.req_size  = 2'd0;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input int w,
                       input logic [31:0] erd, input logic efault, input int elat);
    resp_t e;
    int guard = 0;
    send(we, size, sg, addr, wd, w);
    e.rdata = erd; e.fault = efault; e.lat = elat; e.acc = cyc;
    exp_q.push_back(e);
    while (exp_q.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 60) begin
      check("resp_timeout", 0, 1);
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    dut_if.req_valid  = 1'b0;
    dut_if.req_we     = 1'b0;
    dut_if.req_size   = 2'd0;
    dut_if.req_signed = 1'b0;
    dut_if.req_addr   = 32'h0;
    dut_if.req_wdata  = 32'h0;
    dut_if.bus_ack    = 1'b0;
    dut_if.bus_rdata  = 32'h0;
    mem[32'h100] = 32'h8000_0000;
    mem[32'h1FC] = 32'hAABB_CCDD;
    mem[32'h200] = 32'h1122_3344;

    #3;
    check("rst_req_ready", dut_if.req_ready, 1);
    check("rst_resp_valid", dut_if.resp_valid, 0);
    check("rst_bus_req", dut_if.bus_req, 0);
    check("rst_bus_be", dut_if.bus_be, 0);
    check("rst_resp_rdata", dut_if.resp_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Signed byte load
    expect_bus(0, 32'h100, 4'b1000, 32'h0);
    issue(0, 2'd0, 1, 32'h103, 32'h0, 0, 32'hFFFF_FF80, 0, 2);
    // Unsigned byte load, same lane
    expect_bus(0, 32'h100, 4'b1000, 32'h0);
    issue(0, 2'd0, 0, 32'h103, 32'h0, 0, 32'h0000_0080, 0, 2);
    // Half store
    expect_bus(1, 32'h100, 4'b1100, 32'h1234_0000);
    issue(1, 2'd1, 0, 32'h102, 32'h0000_1234, 0, 32'h0, 0, 2);
    // Aligned word load with two wait cycles
    expect_bus(0, 32'h200, 4'b1111, 32'h0);
    issue(0, 2'd2, 0, 32'h200, 32'h0, 2, 32'h1122_3344, 0, 4);
    // Half loads, low lanes signed and high lanes unsigned
    expect_bus(0, 32'h1FC, 4'b0011, 32'h0);
    issue(0, 2'd1, 1, 32'h1FC, 32'h0, 0, 32'hFFFF_CCDD, 0, 2);
    expect_bus(0, 32'h1FC, 4'b1100, 32'h0);
    issue(0, 2'd1, 0, 32'h1FE, 32'h0, 0, 32'h0000_AABB, 0, 2);

`ifdef LSU_MISALIGNED_SPLIT_EN
    expect_bus(0, 32'h1FC, 4'b1100, 32'h0);
    expect_bus(0, 32'h200, 4'b0011, 32'h0);
    issue(0, 2'd2, 0, 32'h1FE, 32'h0, 0, 32'h3344_AABB, 0, 3);
    expect_bus(1, 32'h1FC, 4'b1000, 32'hEF00_0000);
    expect_bus(1, 32'h200, 4'b0111, 32'h00DE_ADBE);
    issue(1, 2'd2, 0, 32'h1FF, 32'hDEAD_BEEF, 0, 32'h0, 0, 3);
`else
    hi_cnt = 0;
    issue(0, 2'd2, 0, 32'h1FE, 32'h0, 0, 32'h0, 1, 1);
    issue(1, 2'd2, 0, 32'h1FF, 32'hDEAD_BEEF, 0, 32'h0, 1, 1);
    check("nosplit_bus_cycles", hi_cnt, 0);
`endif

    // Illegal dword size on a 32-bit build
    hi_cnt = 0;
    issue(0, 2'd3, 0, 32'h100, 32'h0, 0, 32'h0, 1, 1);
    check("illegal_bus_cycles", hi_cnt, 0);

    // Timeout with no ack
    hi_cnt = 0;
    expect_bus(0, 32'h100, 4'b1111, 32'h0);
    issue(0, 2'd2, 0, 32'h100, 32'h0, 1000, 32'h0, 1, 5);
    check("timeout_bus_req_cycles", hi_cnt, 4);

    // Reset during a BUS1 wait
    expect_bus(0, 32'h100, 4'b1111, 32'h0);
    send(0, 2'd2, 0, 32'h100, 32'h0, 1000);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_bus_req", dut_if.bus_req, 0);
    check("abort_resp_valid", dut_if.resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_req_ready", dut_if.req_ready, 1);
    expect_bus(0, 32'h200, 4'b1111, 32'h0);
    issue(0, 2'd2, 0, 32'h200, 32'h0, 0, 32'h1122_3344, 0, 2);

    repeat (3) @(negedge clk);
    check("resp_queue_empty", exp_q.size(), 0);
    check("bus_queue_empty", bus_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised memory access sequencer between the multi-cycle core's datapath and the external memory bus. It replaces direct `mem_addr`/`mem_data`/`mem_size` driving with a request/response handshake. The bus side uses byte enables and an `ack`-based wait-state handshake with a timeout. Loads are sign- or zero-extended, and misaligned accesses are optionally split into two bus transactions.

## Interface
- `XLEN`, default 32: data width, 32 or 64; `NB = XLEN/8` byte lanes.
- `ADDR_W`, default 32: address width.
- `TIMEOUT`, default 15: maximum consecutive wait cycles per bus phase before fault, minimum 1.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: core requests an access.
- `req_ready` out 1: block is in IDLE and accepts a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: log2 of access bytes (0 = byte, 1 = half, 2 = word, 3 = dword); size 3 is legal only when `XLEN == 64`, otherwise it faults.
- `req_signed` in 1: sign-extend load result.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in XLEN: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out XLEN: extended load data; 0 for stores and faults.
- `resp_fault` out 1: access faulted; qualified by `resp_valid`.
- `bus_req` out 1: bus transaction active.
- `bus_we` out 1: bus write.
- `bus_addr` out ADDR_W: NB-aligned word address.
- `bus_be` out NB: byte enables.
- `bus_wdata` out XLEN: lane-aligned write data.
- `bus_rdata` in XLEN: read data, valid while `bus_ack` is high.
- `bus_ack` in 1: transaction complete this cycle.

## Operation
- **States:**
  - IDLE: `req_ready=1`.
  - BUS1: first word.
  - BUS2: second word, split accesses only.
  - RESP: `resp_valid=1` for exactly one cycle, then IDLE.
- **Accept:**
  - A request is accepted on the edge where `req_valid && req_ready`.
  - The address, size, data and flags are latched at that edge; later input changes are ignored.
- **Lane math:**
  - `off = addr mod NB`, `n = 1 << size`.
  - Lane mask is `((1<<n)-1) << off`.
  - `bus_wdata` is `req_wdata << 8*off`.
- **Aligned case** (`off + n <= NB`):
  - IDLE to BUS1.
  - BUS1 to RESP on `bus_ack`.
- **Split case** (`off + n > NB`):
  - BUS1 uses the low NB bits of the lane mask and ends on `bus_ack`.
  - BUS2 drives `bus_addr + NB`, wrapping modulo 2^ADDR_W. Its enables are the remaining mask bits, and its data carries the remaining shifted bytes.
  - BUS2 to RESP on `bus_ack`.
- **Load result:**
  - Form the `{word2, word1}` concatenation.
  - Shift it right by `8*off`, truncate to n bytes, then extend per `req_signed`.
- **Bus rules:**
  - In BUS1/BUS2, `bus_req` stays at 1 with `bus_addr`, `bus_be`, `bus_wdata` and `bus_we` held stable until `bus_ack` or timeout.
  - `bus_ack` is ignored outside BUS1/BUS2.
- **Timeout:**
  - A per-phase wait counter resets on entry to each bus phase.
  - If `bus_ack` is still absent after `TIMEOUT` cycles in a phase, go to RESP with `resp_fault=1` and `resp_rdata=0`.
  - In the split case, a second-phase timeout still faults. For a store, the first word has already been written; there is no rollback.
- **Illegal size:** go IDLE to RESP directly with a fault; no bus cycle is issued.
- **Back-pressure:** none on the response; the core must take `resp_valid` in its cycle.

## Timing
- **Reset:** state is IDLE and every output is 0 except `req_ready=1`. An in-flight `bus_req` drops asynchronously. No `resp_valid` is issued for the aborted access.
- **Aligned latency:** `bus_ack` in the first BUS1 cycle gives `resp_valid` 2 cycles after the accept edge. Each wait cycle adds 1.
- **Split latency:** minimum 3 cycles after the accept edge.
- **Throughput:** the earliest next accept is the cycle after RESP.
- **Timeout fault:** `bus_req` is high for exactly `TIMEOUT` cycles, then `resp_valid` follows in the next cycle.

## Configuration
- `LSU_MISALIGNED_SPLIT_EN` defined:
  - Misaligned accesses are split as above.
- `LSU_MISALIGNED_SPLIT_EN` undefined:
  - Any access with `off + n > NB` goes IDLE to RESP with `resp_fault=1`, `resp_rdata=0` and no bus cycle; latency is 1 cycle.
  - BUS2 logic is removed.

## Test plan
- **Signed byte load:** LB addr 0x103, signed, `bus_rdata` 0x80000000 with immediate ack.
  - Bus side: `bus_addr` 0x100, `bus_be` 4'b1000.
  - Response: `resp_rdata` 0xFFFFFF80, `resp_valid` 2 cycles after accept.
- **Half store:** SH 0x1234 at 0x102.
  - Bus side: `bus_we=1`, `bus_be` 4'b1100, `bus_wdata` 0x12340000.
  - Response: `resp_rdata=0`, `resp_fault=0`.
- **Split word load** (macro defined): LW 0x1FE; word 0x1FC = 0xAABBCCDD, word 0x200 = 0x11223344.
  - Bus side: be 1100 then 0011.
  - Response: `resp_rdata` 0x3344AABB, 3 cycles after accept.
- **Timeout:** `TIMEOUT=4`, no ack.
  - Bus side: `bus_req` high exactly 4 cycles.
  - Response: `resp_valid` with `resp_fault=1`, `resp_rdata=0`.
- **Reset mid-access:** assert `rst` during BUS1 wait.
  - `bus_req` falls immediately and `resp_valid` never pulses.
  - `req_ready=1` after release; the next aligned LW completes normally.
- **Misaligned without split** (macro undefined): LW 0x1FE.
  - No `bus_req`.
  - Fault response 1 cycle after accept.
